// File: rtl/matrix_mul_seq_if.sv
// Operand/result handshake bundle for matrix_mul_seq.
// The master side issues operands and consumes results; the slave is the multiplier.
interface matrix_mul_seq_if #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*N*DATA_W-1:0]   a_flat;
  logic [N*N*DATA_W-1:0]   b_flat;
  logic                    out_valid;
  logic                    out_ready;
  logic [N*N*OUT_W-1:0]    c_flat;
  logic                    busy;

  modport master (
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  modport slave (
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, c_flat, busy
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential signed N x N matrix multiplier using one multiply-accumulate per cycle.
// Define MATMUL_SATURATE_EN to clamp results to OUT_W; otherwise they wrap.
module matrix_mul_seq #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  matrix_mul_seq_if.slave bus
);
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N);
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned NN    = N * N;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  a_q [N][N];
  logic signed [DATA_W-1:0]  b_q [N][N];
  logic signed [OUT_W-1:0]   c_q [N][N];
  logic [CNT_W-1:0]          i_q, j_q, k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      in_ready_q, out_valid_q, busy_q;

  logic signed [DATA_W-1:0]  a_in [N][N];
  logic signed [DATA_W-1:0]  b_in [N][N];
  logic [NN*OUT_W-1:0]       c_flat_w;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [OUT_W-1:0]   conv_val;
  logic                      k_last, j_last, i_last;

  // Slice 0 of each flat bus is the most-significant field.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      localparam int unsigned Idx = NN - 1 - (gr * N + gc);
      assign a_in[gr][gc] = bus.a_flat[Idx*DATA_W +: DATA_W];
      assign b_in[gr][gc] = bus.b_flat[Idx*DATA_W +: DATA_W];
      assign c_flat_w[Idx*OUT_W +: OUT_W] = c_q[gr][gc];
    end
  end

  assign prod    = a_q[i_q][k_q] * b_q[k_q][j_q];
  assign acc_sum = acc_q + ACC_W'(prod);
  assign k_last  = (k_q == CNT_W'(N - 1));
  assign j_last  = (j_q == CNT_W'(N - 1));
  assign i_last  = (i_q == CNT_W'(N - 1));

  if (OUT_W >= ACC_W) begin : g_conv_ext
    assign conv_val = OUT_W'(acc_sum);
  end else begin : g_conv_narrow
`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;
    always_comb begin
      conv_val = OUT_W'(acc_sum);
      if (acc_sum > SatMax) begin
        conv_val = OUT_W'(SatMax);
      end else if (acc_sum < SatMin) begin
        conv_val = OUT_W'(SatMin);
      end
    end
`else
    assign conv_val = OUT_W'(acc_sum);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      c_q         <= '{default: '0};
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StCalc: begin
          if (k_last) begin
            c_q[i_q][j_q] <= conv_val;
            acc_q         <= '0;
            k_q           <= '0;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                state_q     <= StDone;
                out_valid_q <= 1'b1;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.c_flat    = c_flat_w;
endmodule

// File: tb/tb_matrix_mul_seq.sv
// Scoreboard bench for matrix_mul_seq: a 2x2 and a 3x3 instance driven with directed
// and random operands, checked against an integer reference model.
module tb_matrix_mul_seq;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  logic rst2_n, rst3_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_mul_seq_if #(.N(2), .DATA_W(DW), .OUT_W(OW)) bus2 ();
  matrix_mul_seq_if #(.N(3), .DATA_W(DW), .OUT_W(OW)) bus3 ();

  matrix_mul_seq #(.N(2), .DATA_W(DW), .OUT_W(OW)) dut2 (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus2.slave)
  );
  matrix_mul_seq #(.N(3), .DATA_W(DW), .OUT_W(OW)) dut3 (
    .clk  (clk),
    .rst_n(rst3_n),
    .bus  (bus3.slave)
  );

  logic [143:0] exp2_q[$], exp3_q[$];
  int           hs2_q[$], hs3_q[$], rise3_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Plain integer matrix product, then narrowed to 16 bits.
  function automatic logic [143:0] model(input int n, input logic [71:0] a, input logic [71:0] b);
    logic [143:0] c;
    logic [7:0]   ea, eb;
    logic [31:0]  s;
    int           sum;
    c = '0;
    for (int r = 0; r < n; r++) begin
      for (int cc = 0; cc < n; cc++) begin
        sum = 0;
        for (int k = 0; k < n; k++) begin
          ea = a[(n*n-1-(r*n+k))*8 +: 8];
          eb = b[(n*n-1-(k*n+cc))*8 +: 8];
          sum += int'($signed(ea)) * int'($signed(eb));
        end
`ifdef MATMUL_SATURATE_EN
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
`endif
        s = sum;
        c[(n*n-1-(r*n+cc))*16 +: 16] = s[15:0];
      end
    end
    return c;
  endfunction

  function automatic logic [71:0] rand_mat(input int n);
    logic [71:0] m;
    m = '0;
    for (int e = 0; e < n * n; e++) m[e*8 +: 8] = 8'($urandom());
    return m;
  endfunction

  // Called just after a posedge; returns #1 after the accepting edge.
  task automatic send(input int which, input logic [71:0] a, input logic [71:0] b);
    bit ok;
    ok = 1'b0;
    if (which == 2) begin
      bus2.a_flat = a[31:0]; bus2.b_flat = b[31:0]; bus2.in_valid = 1'b1;
    end else begin
      bus3.a_flat = a; bus3.b_flat = b; bus3.in_valid = 1'b1;
    end
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = (which == 2) ? bus2.in_ready : bus3.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("send");
    else if (which == 2) begin
      exp2_q.push_back(model(2, a, b)); hs2_q.push_back(cyc);
    end else begin
      exp3_q.push_back(model(3, a, b)); hs3_q.push_back(cyc);
    end
    bus2.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
  endtask

  task automatic drain(input int which, input bit rnd_ready);
    int t;
    for (t = 0; t < 2000; t++) begin
      if ((which == 2 ? exp2_q.size() : exp3_q.size()) == 0) break;
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        if (which == 2) bus2.out_ready = 1'($urandom_range(0, 1));
        else bus3.out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (t == 2000) fail_now("drain");
    bus2.out_ready = 1'b1;
    bus3.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  bit          pv2, ph2, pv3, ph3;
  logic [63:0] held2;
  logic [143:0] held3;

  always @(negedge clk) begin
    if (!rst2_n) begin
      pv2 = 1'b0; ph2 = 1'b0;
    end else begin
      chk1("busy_vs_ready2", bus2.busy, !bus2.in_ready);
      if (ph2) chk1("ready_after_out_hs2", bus2.in_ready, 1'b1);
      if (bus2.out_valid) begin
        chk1("ready_in_done2", bus2.in_ready, 1'b0);
        if (!pv2) begin
          held2 = bus2.c_flat;
          if (hs2_q.size() != 0) chki("latency2", cyc - hs2_q.pop_front(), 8);
        end else chkv("hold2", 144'(bus2.c_flat), 144'(held2));
        if (bus2.out_ready) begin
          if (exp2_q.size() == 0) fail_now("unexpected_result2");
          else chkv("result2", 144'(bus2.c_flat), exp2_q.pop_front());
        end
      end
      ph2 = bus2.out_valid && bus2.out_ready;
      pv2 = bus2.out_valid && !bus2.out_ready;
    end
  end

  always @(negedge clk) begin
    if (!rst3_n) begin
      pv3 = 1'b0; ph3 = 1'b0;
    end else begin
      chk1("busy_vs_ready3", bus3.busy, !bus3.in_ready);
      if (ph3) chk1("ready_after_out_hs3", bus3.in_ready, 1'b1);
      if (bus3.out_valid) begin
        chk1("ready_in_done3", bus3.in_ready, 1'b0);
        if (!pv3) begin
          held3 = bus3.c_flat;
          rise3_q.push_back(cyc);
          if (hs3_q.size() != 0) chki("latency3", cyc - hs3_q.pop_front(), 27);
        end else chkv("hold3", bus3.c_flat, held3);
        if (bus3.out_ready) begin
          if (exp3_q.size() == 0) fail_now("unexpected_result3");
          else chkv("result3", bus3.c_flat, exp3_q.pop_front());
        end
      end
      ph3 = bus3.out_valid && bus3.out_ready;
      pv3 = bus3.out_valid && !bus3.out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] a1, b1, ident, b9;
    int t;
    a1 = 72'({8'd1, 8'd2, 8'd3, 8'd4});
    b1 = 72'({8'd5, 8'd6, 8'd7, 8'd8});
    ident = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b9 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    bus2.in_valid = 1'b0; bus2.a_flat = '0; bus2.b_flat = '0; bus2.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.a_flat = '0; bus3.b_flat = '0; bus3.out_ready = 1'b1;
    rst2_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_out_valid", bus2.out_valid, 1'b0);
    chk1("rst_busy", bus2.busy, 1'b0);
    chkv("rst_c_flat", 144'(bus2.c_flat), '0);
    rst2_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_in_ready2", bus2.in_ready, 1'b1);
    chk1("rst_in_ready3", bus3.in_ready, 1'b1);

    // Basic, signed and overflow products
    send(2, a1, b1); drain(2, 1'b0);
    send(2, 72'({8'hFF, 8'h00, 8'h00, 8'hFF}), 72'({8'h03, 8'hFC, 8'h05, 8'h06})); drain(2, 1'b0);
    send(2, 72'(32'h8080_8080), 72'(32'h8080_8080)); drain(2, 1'b0);

    // Backpressure with a competing operand pair presented during DONE
    bus2.out_ready = 1'b0;
    send(2, a1, b1);
    fork
      begin
        for (t = 0; t < 100 && !bus2.out_valid; t++) @(posedge clk);
        if (t == 100) fail_now("wait_out_valid");
        repeat (5) @(posedge clk);
        #1 bus2.out_ready = 1'b1;
        @(posedge clk);
        #1 bus2.out_ready = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        send(2, 72'({8'd9, 8'hF7, 8'd2, 8'd127}), 72'({8'h80, 8'd3, 8'hFE, 8'd11}));
      end
    join
    bus2.out_ready = 1'b1;
    drain(2, 1'b0);

    // Asynchronous reset in the middle of a calculation
    send(2, a1, b1);
    repeat (3) @(posedge clk);
    #2 rst2_n = 1'b0;
    #1;
    chk1("abort_out_valid", bus2.out_valid, 1'b0);
    chk1("abort_busy", bus2.busy, 1'b0);
    chkv("abort_c_flat", 144'(bus2.c_flat), '0);
    exp2_q.delete();
    hs2_q.delete();
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("after_abort_in_ready", bus2.in_ready, 1'b1);
    send(2, a1, b1); drain(2, 1'b0);

    // Random 2x2 traffic with random backpressure
    for (int n = 0; n < 20; n++) begin
      send(2, rand_mat(2), rand_mat(2));
      drain(2, 1'b1);
    end

    // 3x3 back-to-back streaming
    rise3_q.delete();
    send(3, ident, b9);
    send(3, b9, b9);
    drain(3, 1'b0);
    if (rise3_q.size() == 2) chki("stream_spacing3", rise3_q[1] - rise3_q[0], 29);
    else chki("stream_results3", rise3_q.size(), 2);
    for (int n = 0; n < 4; n++) begin
      send(3, rand_mat(3), rand_mat(3));
      drain(3, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_mul_seq.md
# matrix_mul_seq

Parametrised sequential signed matrix multiplier computing C = A × B for square N×N matrices. It uses a single multiply-accumulate datapath iterated over N³ cycles. Operands are accepted through a valid/ready input handshake and the result is returned through a valid/ready output handshake. It is the next-generation replacement for the fixed 2×2 combinational multiplier and is intended for the same flat packed-bus datapath.

## Interface
- `N`, default 2: matrix dimension (N ≥ 2).
- `DATA_W`, default 8: signed operand element width.
- `OUT_W`, default 16: signed result element width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `a_flat` and `b_flat` hold a valid operand pair.
- `in_ready` out 1: block can accept operands.
- `a_flat` in N\*N\*DATA_W: matrix A, packed.
- `b_flat` in N\*N\*DATA_W: matrix B, packed.
- `out_valid` out 1: `c_flat` holds a complete result.
- `out_ready` in 1: consumer accepts the result.
- `c_flat` out N\*N\*OUT_W: matrix C, packed.
- `busy` out 1: high in CALC and DONE.
- Clocking: one clock; reset is asynchronous and active-low.

## Operation
- **Packing:** element (r,c) occupies slice index r\*N+c. Index 0 is the most-significant slice, so for N=2 the order is {m00,m01,m10,m11}. All elements are two's complement.
- **Accumulator:** internal width ACC_W = 2\*DATA_W + $clog2(N). The accumulator never overflows.
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid` && `in_ready`: register A and B, clear i/j/k and the accumulator, go to CALC.
  - Inputs are not sampled again until the next IDLE.
- **CALC:**
  - Each cycle: acc ← acc + A[i][k]·B[k][j], with k incrementing.
  - At k=N−1: write conv(acc + product) to C[i][j], clear acc, set k=0, advance j; on j wrap, advance i.
  - After element (N−1,N−1) is written, go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `c_flat` is stable.
  - On `out_ready`: go to IDLE.
- **`in_ready`:** 0 in CALC and DONE. An `in_valid` asserted in those states is ignored and has no side effects.
- **`c_flat`:** driven directly from the result register. Intermediate values during CALC are don't-care. Contents are meaningful only while `out_valid`=1. The register retains the last result in IDLE.
- **conv():** ACC_W → OUT_W conversion, defined under Configuration.
- **Reset:**
  - All outputs are 0 except `in_ready`, which is 1 once reset is released.
  - FSM goes to IDLE; counters, accumulator, and C all clear.
  - Reset asserted mid-CALC or in DONE aborts the operation. No partial result is ever flagged valid.

## Timing
- Input handshake in cycle T.
- CALC occupies cycles T+1 … T+N³.
- `out_valid` rises at cycle T+N³+1 (registered). For N=2 that is T+9.
- The output handshake in cycle U returns the FSM to IDLE at U+1. `in_ready`=1 from U+1.
- Back-to-back throughput with `out_ready` tied high: one result per N³+2 cycles.
- While `out_valid`=1 and `out_ready`=0, `out_valid` and `c_flat` hold indefinitely.
- `busy` = (state ≠ IDLE), registered.

## Configuration
- **`MATMUL_SATURATE_EN` defined:** conv() clamps to the range [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **`MATMUL_SATURATE_EN` undefined:** conv() truncates to the low OUT_W bits (two's-complement wrap).
- **When OUT_W ≥ ACC_W:** conv() sign-extends in both builds, and the macro has no effect.

## Test plan
Scenarios 1–5 use N=2, DATA_W=8, OUT_W=16.
1. **Basic product:** A=[[1,2],[3,4]], B=[[5,6],[7,8]] handshaken at T → `out_valid` at T+9 with C=[[19,22],[43,50]]. `in_ready`=0 from T+1 to the output handshake.
2. **Signed operands:** A=[[−1,0],[0,−1]], B=[[3,−4],[5,6]] → C=[[−3,4],[−5,−6]].
3. **Overflow:** all A and B elements = −128, so each element sum is 32768.
   - With `MATMUL_SATURATE_EN`: every C element = 0x7FFF.
   - Without it: every C element = 0x8000.
4. **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid`, and a second `in_valid` with different data is presented.
   - `out_valid` and `c_flat` must stay unchanged and `in_ready` must stay 0.
   - After `out_ready` pulses, `in_ready`=1 the next cycle.
   - The second operand pair is then accepted and produces its own correct result.
5. **Reset mid-operation:** `rst_n` low asynchronously at T+4 of scenario 1.
   - Immediately: `out_valid`=0, `busy`=0, `c_flat`=0.
   - After release: `in_ready`=1, and a fresh scenario-1 run returns [[19,22],[43,50]].
6. **N=3 streaming:** N=3, `out_ready` held high.
   - Operand pairs: A=identity with B=[[1..9]] row-major, then A=B=[[1..9]], presented back-to-back.
   - First result is B. Second result is [[30,36,42],[66,81,96],[102,126,150]].
   - Results are spaced 29 cycles apart.
